// File: rtl/switch_input_capture.sv
// Switch-bus capture stage: synchronises SW/nKey, debounces the button and latches SW once per press.
// Build with SWCAP_OVERRUN_EN defined to add the sticky overrun output.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | button released and stable, waiting for a press
//   DB_PRESS | button seen low, counting stable-low cycles before capture
//   HELD     | press accepted and captured, waiting for release
//   DB_REL   | button seen high, counting stable-high cycles before IDLE
module switch_input_capture #(
    parameter int DATA_W          = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [DATA_W-1:0] SW,
    input  logic              nKey,
    input  logic              ack,
    output logic [DATA_W-1:0] usr_input,
    output logic              data_ready,
`ifdef SWCAP_OVERRUN_EN
    output logic              overrun,
`endif
    output logic              key_busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_t;

    logic [DATA_W-1:0]      sw_sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] key_sync_q;
    logic [DATA_W-1:0]      sw_s;
    logic                   key_s;
    logic                   key_low;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   capture;

    logic [DATA_W-1:0]      usr_q, usr_d;
    logic                   ready_q, ready_d;

    // The key synchroniser resets to 1 so a button held through reset is not seen as a press edge early.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync_q[i] <= '0;
            end
            key_sync_q <= '1;
        end else begin
            sw_sync_q[0] <= SW;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync_q[i] <= sw_sync_q[i-1];
            end
            key_sync_q <= {key_sync_q[SYNC_STAGES-2:0], nKey};
        end
    end

    assign sw_s    = sw_sync_q[SYNC_STAGES-1];
    assign key_s   = key_sync_q[SYNC_STAGES-1];
    assign key_low = !key_s;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_low) begin
                    state_d = DB_PRESS;
                    cnt_d   = '0;
                end
            end
            DB_PRESS: begin
                if (!key_low) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!key_low) begin
                    state_d = DB_REL;
                    cnt_d   = '0;
                end
            end
            DB_REL: begin
                if (key_low) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture outranks ack: a fresh value must never be hidden by a stale acknowledge.
    always_comb begin
        usr_d   = usr_q;
        ready_d = ready_q;
        if (capture) begin
            usr_d   = sw_s;
            ready_d = 1'b1;
        end else if (ack) begin
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            usr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            usr_q   <= usr_d;
            ready_q <= ready_d;
        end
    end

`ifdef SWCAP_OVERRUN_EN
    logic ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (ack && ready_q) begin
            ovr_d = 1'b0;
        end else if (capture && ready_q) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun = ovr_q;
`endif

    assign usr_input  = usr_q;
    assign data_ready = ready_q;
    assign key_busy   = (state_q != IDLE);

endmodule
